// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the data memory arbiter
package mem_arb_pkg;

  typedef enum logic {IDLE, ACCESS} arb_state_t;

  localparam int DATA_W = 8;

endpackage

// File: rtl/data_mem_arbiter_rr_pick.sv
// rtl/data_mem_arbiter_rr_pick.sv - round-robin winner select, scanning upward from ptr with wrap
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            valid
);

  always_comb begin
    logic [PW-1:0] idx;
    idx   = '0;
    win   = '0;
    valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter sharing the single-port data memory
import mem_arb_pkg::*;

module data_mem_arbiter #(
  parameter int AW   = 8,
  parameter int NREQ = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              lock,
  input  logic [NREQ-1:0]              we,
  input  logic [NREQ-1:0][AW-1:0]      addr,
  input  logic [NREQ-1:0][DATA_W-1:0]  wdata,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              rvalid,
  output logic [DATA_W-1:0]            rdata,
  output logic                         busy,
  output logic [AW-1:0]                mem_addr,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   rrPtr;
  logic [OW-1:0]   rrPtrNext;
  logic [OW-1:0]   pickPtr;
  logic [OW-1:0]   pickWin;
  logic [NREQ-1:0] ownerHot;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pickReq;
  logic            pickValid;
  logic            access;
  logic            holdLock;

  assign access    = (state == ACCESS);
  assign ownerHot  = NREQ'(1) << owner;
  assign rrPtrNext = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
  assign cand      = req & ~ownerHot;
  assign holdLock  = lock[owner] & req[owner];

  // One picker serves both cases: fresh arbitration from IDLE, or the
  // follow-on pick at the end of an access with the current owner masked.
  assign pickReq = access ? cand : req;
  assign pickPtr = access ? rrPtrNext : rrPtr;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (OW)
  ) uPick (
    .req   (pickReq),
    .ptr   (pickPtr),
    .win   (pickWin),
    .valid (pickValid)
  );

  // Memory strobes follow state directly, so an async reset kills a store at once.
  assign busy      = access;
  assign gnt       = access ? ownerHot : '0;
  assign mem_write = access & we[owner];
  assign mem_read  = access & ~we[owner];
  assign mem_addr  = access ? addr[owner] : '0;
  assign mem_wdata = access ? wdata[owner] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rrPtr  <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (access) begin
        rrPtr <= rrPtrNext;
        if (!we[owner]) begin
          rdata  <= mem_rdata;
          rvalid <= ownerHot;
        end
        if (!holdLock) begin
          if (pickValid) begin
            owner <= pickWin;
          end else begin
            state <= IDLE;
          end
        end
      end else if (pickValid) begin
        owner <= pickWin;
        state <= ACCESS;
      end
    end
  end

endmodule
